bp_fe_queue_pairer: RTL and testbench

//  FE-side producer for the dual-slot FE->BE queue. Accepts one bp_fe_queue_s per cycle from
//  the FE fetch pipeline, buffers it, and presents it to the BE issue queue as a slot pair
//  (slot1 older, slot2 younger). Exception messages always go alone. A lone fetch packet is

---
 rtl/bp_fe_pkg.sv | 17 +
 rtl/bp_fe_pair_buffer.sv | 39 +++
 rtl/bp_fe_queue_pairer.sv | 94 +++++++++
 tb/tb_bp_fe_queue_pairer.sv | 134 +++++++++++++
 4 files changed

// File: rtl/bp_fe_pkg.sv
// bp_fe_pkg: FE queue message types and pairer state shared by the FE queue pairer
package bp_fe_pkg;
  typedef enum logic {e_bp_default_cfg} bp_params_e;
  typedef enum logic {e_fe_fetch, e_fe_exception} bp_fe_queue_type_e;
  typedef struct packed {
    bp_fe_queue_type_e msg_type;
    logic [38:0]       pc;
    logic [31:0]       instr;
  } bp_fe_queue_s;
  typedef enum logic {e_out_idle, e_out_valid} bp_fe_pairer_state_e;
  function automatic int bp_fe_queue_width_f(input bp_params_e cfg);
    return (cfg == e_bp_default_cfg) ? $bits(bp_fe_queue_s) : 0;
  endfunction
  function automatic logic is_exception(input bp_fe_queue_s pkt);
    return pkt.msg_type == e_fe_exception;
  endfunction
endpackage

// File: rtl/bp_fe_pair_buffer.sv
// bp_fe_pair_buffer: circular buffer with one write port, a two-entry head peek and 0/1/2 pop
module bp_fe_pair_buffer #(
  parameter int width_p = 8,
  parameter int els_p = 4,
  localparam int lg_lp = $clog2(els_p),
  localparam int cw_lp = lg_lp + 1
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               clear_i,
  input  logic [width_p-1:0] wdata_i,
  input  logic               push_i,
  input  logic [1:0]         pop_i,
  output logic [width_p-1:0] h_o,
  output logic [width_p-1:0] n_o,
  output logic [cw_lp-1:0]   count_o,
  output logic               full_o
);
  logic [width_p-1:0] r_mem [els_p];
  logic [cw_lp-1:0]   r_rptr, r_wptr;
  logic [lg_lp-1:0]   w_nidx;
  always_ff @(posedge clk_i) begin
    if (reset_i | clear_i) begin
      r_rptr <= '0;
      r_wptr <= '0;
    end else begin
      r_wptr <= r_wptr + cw_lp'(push_i);
      r_rptr <= r_rptr + cw_lp'(pop_i);
    end
  end
  always_ff @(posedge clk_i) begin
    if (push_i) r_mem[r_wptr[lg_lp-1:0]] <= wdata_i;
  end
  assign w_nidx  = r_rptr[lg_lp-1:0] + lg_lp'(1);
  assign h_o     = r_mem[r_rptr[lg_lp-1:0]];
  assign n_o     = r_mem[w_nidx];
  assign count_o = r_wptr - r_rptr;
  assign full_o  = (r_wptr[lg_lp-1:0] == r_rptr[lg_lp-1:0]) & (r_wptr[lg_lp] != r_rptr[lg_lp]);
endmodule

// File: rtl/bp_fe_queue_pairer.sv
// bp_fe_queue_pairer: buffers FE queue packets and issues them to the BE as older/younger slot pairs
module bp_fe_queue_pairer
  import bp_fe_pkg::*;
#(
  parameter bp_params_e bp_params_p = e_bp_default_cfg,
  parameter int buf_els_p = 4,
  parameter int pair_timeout_p = 3,
  localparam int fe_queue_width_lp = bp_fe_queue_width_f(bp_params_p)
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic                         flush_i,
  input  logic [fe_queue_width_lp-1:0] fetch_pkt_i,
  input  logic                         fetch_v_i,
  output logic                         fetch_ready_o,
  output logic [fe_queue_width_lp-1:0] fe_queue1_o,
  output logic [fe_queue_width_lp-1:0] fe_queue2_o,
  output logic                         fe_queue_v1_o,
  output logic                         fe_queue_v2_o,
  input  logic                         fe_queue_ready_i
);
  localparam int cw_lp = $clog2(buf_els_p) + 1;
  localparam int tw_lp = (pair_timeout_p > 0) ? $clog2(pair_timeout_p + 1) : 1;
  localparam logic [tw_lp-1:0] timeout_lp = tw_lp'(pair_timeout_p);
  bp_fe_pairer_state_e          r_state;
  logic [fe_queue_width_lp-1:0] r_q1, r_q2;
  logic                         r_v1, r_v2;
  logic [tw_lp-1:0]             r_timer;
  bp_fe_queue_s                 w_h, w_n, w_n_eff;
  logic [cw_lp-1:0]             w_count;
  logic                         w_full, w_push, w_can_load, w_n_avail, w_h_exc, w_n_exc;
  logic                         w_pair, w_single, w_load;
  logic [1:0]                   w_pop;
  bp_fe_pair_buffer #(
    .width_p(fe_queue_width_lp),
    .els_p  (buf_els_p)
  ) buffer (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .clear_i(flush_i),
    .wdata_i(fetch_pkt_i),
    .push_i (w_push),
    .pop_i  (w_pop),
    .h_o    (w_h),
    .n_o    (w_n),
    .count_o(w_count),
    .full_o (w_full)
  );
  assign fetch_ready_o = ~w_full & ~flush_i & ~reset_i;
  assign w_push        = fetch_v_i & fetch_ready_o;
  // A lone buffered head may pair with the beat arriving this cycle
  always_comb begin
    w_n_avail  = (w_count >= cw_lp'(2)) | ((w_count == cw_lp'(1)) & w_push);
    w_n_eff    = (w_count >= cw_lp'(2)) ? w_n : bp_fe_queue_s'(fetch_pkt_i);
    w_h_exc    = is_exception(w_h);
    w_n_exc    = is_exception(w_n_eff);
    w_can_load = (r_state == e_out_idle) | fe_queue_ready_i;
    w_pair     = w_can_load & w_n_avail & ~w_h_exc & ~w_n_exc;
    w_single   = w_can_load & ~w_pair & (w_count != '0)
               & (w_h_exc | (w_n_avail & w_n_exc) | (r_timer == timeout_lp));
    w_load     = w_pair | w_single;
    w_pop      = w_pair ? 2'd2 : w_single ? 2'd1 : 2'd0;
  end
  always_ff @(posedge clk_i) begin
    if (reset_i | flush_i) r_timer <= '0;
    else if ((w_pop != 2'd0) | (w_push & (w_count == '0))) r_timer <= '0;
    else if ((w_count == cw_lp'(1)) & ~w_h_exc & (r_timer != timeout_lp)) r_timer <= r_timer + tw_lp'(1);
  end
  always_ff @(posedge clk_i) begin
    if (reset_i | flush_i) begin
      r_state <= e_out_idle;
      r_v1    <= 1'b0;
      r_v2    <= 1'b0;
      r_q1    <= '0;
      r_q2    <= '0;
    end else if (w_load) begin
      r_state <= e_out_valid;
      r_v1    <= 1'b1;
      r_v2    <= w_pair;
      r_q1    <= w_h;
      r_q2    <= w_pair ? w_n_eff : '0;
    end else if ((r_state == e_out_valid) & fe_queue_ready_i) begin
      r_state <= e_out_idle;
      r_v1    <= 1'b0;
      r_v2    <= 1'b0;
      r_q1    <= '0;
      r_q2    <= '0;
    end
  end
  assign fe_queue1_o   = r_q1;
  assign fe_queue2_o   = r_q2;
  assign fe_queue_v1_o = r_v1;
  assign fe_queue_v2_o = r_v2;
endmodule

// File: tb/tb_bp_fe_queue_pairer.sv
// tb_bp_fe_queue_pairer: directed and random checks of the FE queue pairer against a queue model
module tb_bp_fe_queue_pairer;
  import bp_fe_pkg::*;
  localparam int W = $bits(bp_fe_queue_s);
  localparam int BUF = 4;
  localparam int TO = 3;
  logic clk = 1'b0;
  logic reset_i, flush_i, fetch_v_i, fetch_ready_o;
  logic fe_queue_v1_o, fe_queue_v2_o, fe_queue_ready_i;
  logic [W-1:0] fetch_pkt_i, fe_queue1_o, fe_queue2_o;
  int n_checks = 0, n_err = 0, pc_ctr = 1, lat;
  bp_fe_queue_s m_q[$], ord[$];
  bp_fe_queue_s m_o1 = '0, m_o2 = '0;
  logic m_v1 = 1'b0, m_v2 = 1'b0;
  int m_wait = 0;
  always #5 clk = ~clk;
  bp_fe_queue_pairer #(.buf_els_p(BUF), .pair_timeout_p(TO)) dut (
    .clk_i(clk), .reset_i(reset_i), .flush_i(flush_i),
    .fetch_pkt_i(fetch_pkt_i), .fetch_v_i(fetch_v_i), .fetch_ready_o(fetch_ready_o),
    .fe_queue1_o(fe_queue1_o), .fe_queue2_o(fe_queue2_o),
    .fe_queue_v1_o(fe_queue_v1_o), .fe_queue_v2_o(fe_queue_v2_o),
    .fe_queue_ready_i(fe_queue_ready_i)
  );
  function automatic bp_fe_queue_s mk(input logic e);
    bp_fe_queue_s p;
    p.msg_type = e ? e_fe_exception : e_fe_fetch;
    p.pc = 39'(pc_ctr);
    p.instr = $urandom;
    pc_ctr++;
    return p;
  endfunction
  function automatic logic ex(input bp_fe_queue_s p);
    return p.msg_type == e_fe_exception;
  endfunction
  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic tick(input logic fv, input bp_fe_queue_s pkt, input logic rdy, input logic fl, input logic rs);
    bp_fe_queue_s view[$];
    logic er, push, pair, single;
    int old, npop;
    reset_i = rs; flush_i = fl; fetch_v_i = fv; fetch_pkt_i = pkt; fe_queue_ready_i = rdy;
    #1;
    er = !rs && !fl && m_q.size() < BUF;
    chk("fetch_ready", W'(fetch_ready_o), W'(er));
    push = fv && er;
    if (rs || fl) begin
      m_q.delete(); ord.delete();
      m_v1 = 0; m_v2 = 0; m_o1 = '0; m_o2 = '0; m_wait = 0;
    end else begin
      if (m_v1 && rdy) begin
        chk("order_slot1", fe_queue1_o, ord.size() > 0 ? ord[0] : '0);
        if (ord.size() > 0) void'(ord.pop_front());
        if (fe_queue_v2_o) begin
          chk("order_slot2", fe_queue2_o, ord.size() > 0 ? ord[0] : '0);
          if (ord.size() > 0) void'(ord.pop_front());
        end
      end
      if (push) ord.push_back(pkt);
      old = m_q.size();
      if (old >= 1) view.push_back(m_q[0]);
      if (old >= 2) view.push_back(m_q[1]);
      else if (old == 1 && push) view.push_back(pkt);
      pair = 0; single = 0;
      if (!m_v1 || rdy) begin
        if (view.size() == 2 && !ex(view[0]) && !ex(view[1])) pair = 1;
        else if (view.size() >= 1 && (ex(view[0]) || (view.size() == 2 && ex(view[1])) || m_wait == TO)) single = 1;
      end
      if (pair) begin m_o1 = view[0]; m_o2 = view[1]; m_v1 = 1; m_v2 = 1; end
      else if (single) begin m_o1 = view[0]; m_o2 = '0; m_v1 = 1; m_v2 = 0; end
      else if (m_v1 && rdy) begin m_o1 = '0; m_o2 = '0; m_v1 = 0; m_v2 = 0; end
      if (push) m_q.push_back(pkt);
      npop = pair ? 2 : single ? 1 : 0;
      repeat (npop) void'(m_q.pop_front());
      if (npop > 0 || (old == 0 && push)) m_wait = 0;
      else if (old == 1 && !ex(m_q[0]) && m_wait < TO) m_wait++;
    end
    @(negedge clk);
    chk("v1", W'(fe_queue_v1_o), W'(m_v1));
    chk("v2", W'(fe_queue_v2_o), W'(m_v2));
    if (m_v1) begin
      chk("slot1", fe_queue1_o, m_o1);
      chk("slot2", fe_queue2_o, m_o2);
    end
  endtask
  initial begin
    reset_i = 1; flush_i = 0; fetch_v_i = 0; fetch_pkt_i = '0; fe_queue_ready_i = 0;
    @(negedge clk);
    tick(0, '0, 0, 0, 1);
    tick(1, mk(0), 1, 0, 1);
    chk("reset_slot1", fe_queue1_o, '0);
    chk("reset_slot2", fe_queue2_o, '0);
    // four back-to-back beats pair up
    for (int i = 0; i < 4; i++) tick(1, mk(0), 1, 0, 0);
    repeat (4) tick(0, '0, 1, 0, 0);
    // lone beat waits for the timeout
    lat = -1;
    tick(1, mk(0), 1, 0, 0);
    for (int i = 1; i <= 8; i++) begin
      tick(0, '0, 1, 0, 0);
      if (lat < 0 && fe_queue_v1_o) lat = i;
    end
    chk("timeout_latency", W'(lat), W'(4));
    // exception in the middle is never paired
    tick(1, mk(0), 1, 0, 0);
    tick(1, mk(1), 1, 0, 0);
    tick(1, mk(0), 1, 0, 0);
    repeat (8) tick(0, '0, 1, 0, 0);
    // stalled BE: buffer fills, then drains without bubbles
    for (int i = 0; i < 6; i++) tick(1, mk(0), 0, 0, 0);
    chk("full_ready_low", W'(fetch_ready_o), W'(0));
    repeat (6) tick(0, '0, 1, 0, 0);
    // flush with a pair out and two buffered beats
    for (int i = 0; i < 4; i++) tick(1, mk(0), 0, 0, 0);
    tick(1, mk(0), 1, 1, 0);
    repeat (6) tick(0, '0, 1, 0, 0);
    // reset mid-stream
    for (int i = 0; i < 3; i++) tick(1, mk(0), 1, 0, 0);
    tick(1, mk(0), 1, 0, 1);
    repeat (6) tick(0, '0, 1, 0, 0);
    // random soak
    for (int i = 0; i < 1500; i++)
      tick($urandom_range(0, 9) < 7, mk($urandom_range(0, 4) == 0), $urandom_range(0, 9) < 6,
           $urandom_range(0, 49) == 0, $urandom_range(0, 99) == 0);
    repeat (20) tick(0, '0, 1, 0, 0);
    chk("drained", W'(ord.size()), W'(0));
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
